branch_predictor_param: RTL and testbench
=========================================

BRANCH_PREDICTOR_PARAM -- requirements
Module: branch_predictor_param

Interface
REQ-001 The block SHALL have parameter ENTRIES, default 64, giving BHT/BTB entry count; power of 2, range 4..1024; IDX_W = log2(ENTRIES).
REQ-002 The block SHALL have parameter CTR_W, default 2, giving saturating-counter width, range 1..4.
REQ-003 The block SHALL have parameter GHR_W, default 8, giving global-history width, range 1..16.
REQ-004 The block SHALL have parameter MODE, default 1, selecting the predictor: 0 static-not-taken, 1 bimodal, 2 gshare.
REQ-005 The block SHALL have one clock and an asynchronous, active-high reset, on ports named as below.
REQ-006 The block SHALL have port CLK, input, 1 bit: clock, all state on rising edge.
REQ-007 The block SHALL have port RST, input, 1 bit: asynchronous active-high reset.
REQ-008 The block SHALL have port lookup_valid, input, 1 bit: lookup request for lookup_pc this cycle.
REQ-009 The block SHALL have port lookup_pc, input, 32 bits: fetch PC.
REQ-010 The block SHALL have port pred_valid, output, 1 bit: prediction outputs valid.
REQ-011 The block SHALL have port pred_taken, output, 1 bit: predicted taken.
REQ-012 The block SHALL have port pred_target, output, 32 bits: predicted target, 0 on BTB miss.
REQ-013 The block SHALL have port pred_idx, output, IDX_W bits: BHT index used, returned at update.
REQ-014 The block SHALL have port update_valid, input, 1 bit: resolved control-flow instruction this cycle.
REQ-015 The block SHALL have port update_pc, input, 32 bits: PC of resolved instruction.
REQ-016 The block SHALL have port update_opcode, input, 7 bits: opcode of resolved instruction.
REQ-017 The block SHALL have port update_idx, input, IDX_W bits: pred_idx captured at lookup.
REQ-018 The block SHALL have port update_taken, input, 1 bit: actual outcome.
REQ-019 The block SHALL have port update_pred_taken, input, 1 bit: prediction given at lookup.
REQ-020 The block SHALL have port update_target, input, 32 bits: actual target.
REQ-021 The block SHALL have port branch_count, output, 32 bits: counted control-flow updates.
REQ-022 The block SHALL have port mispredict_count, output, 32 bits: counted mispredictions.

Function
REQ-023 Bimodal index SHALL be lookup_pc[IDX_W+1:2]; gshare index SHALL be that XOR GHR (GHR zero-extended or truncated to IDX_W); the BTB tag SHALL be pc[31:IDX_W+2].
REQ-024 Lookup SHALL be registered: pred_valid SHALL equal lookup_valid delayed by exactly one cycle, with pred_* reflecting state before that edge.
REQ-025 BTB hit SHALL require valid=1 and tag match; jump entries (is_jump=1) on hit SHALL give pred_taken=1 in every MODE.
REQ-026 For a conditional entry hit, pred_taken SHALL be 0 in MODE 0 and counter MSB in MODE 1/2; on BTB miss pred_taken SHALL be 0 and pred_target SHALL be 0.
REQ-027 When update_opcode=1100011 (branch), BHT[update_idx] SHALL increment on taken / decrement on not-taken, saturating at 0 and 2^CTR_W-1.
REQ-028 For update_opcode=1100011, GHR SHALL shift to {GHR[GHR_W-2:0], update_taken}; GHR_W=1 SHALL load update_taken.
REQ-029 For update_opcode=1100011 with update_taken=1, the BTB entry at update_pc index SHALL be written: valid=1, tag, target, is_jump=0.
REQ-030 When update_opcode is 1101111 or 1100111 (JAL/JALR), the BTB SHALL be written with is_jump=1, with no BHT or GHR change.
REQ-031 Any other update_opcode SHALL be ignored: no state change, no count.
REQ-032 branch_count SHALL increment on each counted update; mispredict_count SHALL increment when update_taken != update_pred_taken; both SHALL wrap modulo 2^32.
REQ-033 On simultaneous lookup and update to the same index, the lookup SHALL see pre-update state (read-before-write); the update SHALL still complete.
REQ-034 Reset mid-operation SHALL discard any in-flight lookup: pred_valid=0 in the cycle after RST deasserts unless lookup_valid was 1 in the preceding cycle.

Reset
REQ-035 While RST=1, every BHT counter SHALL be 2^(CTR_W-1)-1 (weakly not-taken), every BTB valid=0, GHR=0, branch_count=0, mispredict_count=0, and pred_valid, pred_taken, pred_target, pred_idx=0.

Verification
REQ-036 After reset, MODE=1: lookup 0x100 -> next cycle pred_valid=1, pred_taken=0, pred_target=0.
REQ-037 MODE=1, CTR_W=2: two updates for branch 0x100 taken, target 0x80 -> lookup 0x100 gives pred_taken=1, pred_target=0x80; counter saturates at 3 after further updates.
REQ-038 JAL 0x200 -> 0x400 updated with MODE=0 -> lookup 0x200 gives pred_taken=1, pred_target=0x400; branch_count=1.
REQ-039 ENTRIES=64: branch at 0x100 taken, then lookup 0x200 (same index, tag differs) -> pred_taken=0 (miss).
REQ-040 Lookup and taken update of 0x100 in the same cycle -> prediction reflects old counter; a following lookup reflects the new one.
REQ-041 update_taken=1, update_pred_taken=0, opcode 0110011 -> no count; opcode 1100011 -> mispredict_count +1; assert RST mid-stream -> all counts return to 0.

Source files
------------

// File: rtl/branch_predictor_param.sv
// -----------------------------------------------------------------------------
// branch_predictor_param
//
// Parameterised branch predictor: a direct-mapped BTB plus a BHT of saturating
// counters. MODE selects static-not-taken (0), bimodal (1) or gshare (2).
//
// Ports
//   CLK, RST           clock (rising edge) / asynchronous active-high reset
//   lookup_valid/_pc   fetch lookup request
//   pred_valid         registered prediction valid (lookup_valid delayed 1)
//   pred_taken         predicted direction
//   pred_target        predicted target, 0 on BTB miss
//   pred_idx           BHT index used, handed back on update_idx
//   update_*           resolved control-flow instruction from execute
//   branch_count       counted branch/JAL/JALR updates (wraps at 2^32)
//   mispredict_count   counted updates whose outcome differed from prediction
// -----------------------------------------------------------------------------
module branch_predictor_param #(
   parameter int ENTRIES = 64,
   parameter int CTR_W   = 2,
   parameter int GHR_W   = 8,
   parameter int MODE    = 1,
   localparam int IDX_W  = $clog2(ENTRIES)
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             lookup_valid,
   input  logic [31:0]      lookup_pc,
   output logic             pred_valid,
   output logic             pred_taken,
   output logic [31:0]      pred_target,
   output logic [IDX_W-1:0] pred_idx,
   input  logic             update_valid,
   input  logic [31:0]      update_pc,
   input  logic [6:0]       update_opcode,
   input  logic [IDX_W-1:0] update_idx,
   input  logic             update_taken,
   input  logic             update_pred_taken,
   input  logic [31:0]      update_target,
   output logic [31:0]      branch_count,
   output logic [31:0]      mispredict_count
);

   localparam int TAG_W = 30 - IDX_W;
   // Weakly not-taken: MSB clear, all lower bits set (0 for a 1-bit counter).
   localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'((1 << (CTR_W - 1)) - 1);
   localparam logic [CTR_W-1:0] CTR_MAX  = '1;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   // Predictor state. Kept in flops because every entry must take a
   // reset value asynchronously.
   logic [CTR_W-1:0]   bht_q        [ENTRIES];
   logic [CTR_W-1:0]   bht_d        [ENTRIES];
   logic [TAG_W-1:0]   btb_tag_q    [ENTRIES];
   logic [TAG_W-1:0]   btb_tag_d    [ENTRIES];
   logic [31:0]        btb_target_q [ENTRIES];
   logic [31:0]        btb_target_d [ENTRIES];
   logic [ENTRIES-1:0] btb_valid_q, btb_valid_d;
   logic [ENTRIES-1:0] btb_jump_q, btb_jump_d;
   logic [GHR_W-1:0]   ghr_q, ghr_d, ghr_shift;
   logic [31:0]        branch_count_q, branch_count_d;
   logic [31:0]        mispredict_count_q, mispredict_count_d;

   logic               pred_valid_q, pred_valid_d;
   logic               pred_taken_q, pred_taken_d;
   logic [31:0]        pred_target_q, pred_target_d;
   logic [IDX_W-1:0]   pred_idx_q, pred_idx_d;

   // Word-aligned PCs: the two low bits never select anything.
   logic unused_pc_bits;
   assign unused_pc_bits = ^{lookup_pc[1:0], update_pc[1:0]};

   // History register next value; a 1-bit history simply holds the last outcome.
   generate
      if (GHR_W == 1) begin : g_ghr_one
         assign ghr_shift = update_taken;
      end else begin : g_ghr_many
         assign ghr_shift = {ghr_q[GHR_W-2:0], update_taken};
      end
   endgenerate

   // ---------------------------------------------------------------- lookup
   logic [IDX_W-1:0] lk_pc_idx;
   logic [IDX_W-1:0] lk_bht_idx;
   logic [TAG_W-1:0] lk_tag;
   logic             lk_hit;

   always_comb begin
      lk_pc_idx  = lookup_pc[IDX_W+1:2];
      lk_tag     = lookup_pc[31:IDX_W+2];
      // The BTB is always indexed by PC; only the BHT index is hashed with
      // history in gshare mode.
      lk_bht_idx = (MODE == 2) ? (lk_pc_idx ^ IDX_W'(ghr_q)) : lk_pc_idx;
      lk_hit     = btb_valid_q[lk_pc_idx] && (btb_tag_q[lk_pc_idx] == lk_tag);

      pred_valid_d  = lookup_valid;
      pred_taken_d  = 1'b0;
      pred_target_d = '0;
      pred_idx_d    = '0;
      if (lookup_valid) begin
         pred_idx_d = lk_bht_idx;
         if (lk_hit) begin
            pred_target_d = btb_target_q[lk_pc_idx];
            if (btb_jump_q[lk_pc_idx]) begin
               pred_taken_d = 1'b1;
            end else if (MODE != 0) begin
               pred_taken_d = bht_q[lk_bht_idx][CTR_W-1];
            end
         end
      end
   end

   // ---------------------------------------------------------------- update
   logic             up_is_branch;
   logic             up_is_jump;
   logic [IDX_W-1:0] up_pc_idx;

   always_comb begin
      up_is_branch = (update_opcode == OP_BRANCH);
      up_is_jump   = (update_opcode == OP_JAL) || (update_opcode == OP_JALR);
      up_pc_idx    = update_pc[IDX_W+1:2];

      bht_d              = bht_q;
      btb_tag_d          = btb_tag_q;
      btb_target_d       = btb_target_q;
      btb_valid_d        = btb_valid_q;
      btb_jump_d         = btb_jump_q;
      ghr_d              = ghr_q;
      branch_count_d     = branch_count_q;
      mispredict_count_d = mispredict_count_q;

      if (update_valid) begin
         if (up_is_branch) begin
            if (update_taken) begin
               if (bht_q[update_idx] != CTR_MAX) begin
                  bht_d[update_idx] = bht_q[update_idx] + CTR_W'(1);
               end
            end else if (bht_q[update_idx] != '0) begin
               bht_d[update_idx] = bht_q[update_idx] - CTR_W'(1);
            end
            ghr_d = ghr_shift;
         end

         // Not-taken branches leave the BTB alone so an older taken target
         // survives a single fall-through.
         if ((up_is_branch && update_taken) || up_is_jump) begin
            btb_valid_d[up_pc_idx]  = 1'b1;
            btb_jump_d[up_pc_idx]   = up_is_jump;
            btb_tag_d[up_pc_idx]    = update_pc[31:IDX_W+2];
            btb_target_d[up_pc_idx] = update_target;
         end

         if (up_is_branch || up_is_jump) begin
            branch_count_d = branch_count_q + 32'd1;
            if (update_taken != update_pred_taken) begin
               mispredict_count_d = mispredict_count_q + 32'd1;
            end
         end
      end
   end

   // ------------------------------------------------------------- registers
   // Lookup reads *_q while the update writes *_d, so a same-cycle lookup
   // naturally sees the pre-update state.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < ENTRIES; i++) begin
            bht_q[i]        <= CTR_INIT;
            btb_tag_q[i]    <= '0;
            btb_target_q[i] <= '0;
         end
         btb_valid_q        <= '0;
         btb_jump_q         <= '0;
         ghr_q              <= '0;
         branch_count_q     <= '0;
         mispredict_count_q <= '0;
         pred_valid_q       <= 1'b0;
         pred_taken_q       <= 1'b0;
         pred_target_q      <= '0;
         pred_idx_q         <= '0;
      end else begin
         bht_q              <= bht_d;
         btb_tag_q          <= btb_tag_d;
         btb_target_q       <= btb_target_d;
         btb_valid_q        <= btb_valid_d;
         btb_jump_q         <= btb_jump_d;
         ghr_q              <= ghr_d;
         branch_count_q     <= branch_count_d;
         mispredict_count_q <= mispredict_count_d;
         pred_valid_q       <= pred_valid_d;
         pred_taken_q       <= pred_taken_d;
         pred_target_q      <= pred_target_d;
         pred_idx_q         <= pred_idx_d;
      end
   end

   assign pred_valid       = pred_valid_q;
   assign pred_taken       = pred_taken_q;
   assign pred_target      = pred_target_q;
   assign pred_idx         = pred_idx_q;
   assign branch_count     = branch_count_q;
   assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_predictor_param.sv
// -----------------------------------------------------------------------------
// tb_branch_predictor_param
//
// Three predictor instances (static, bimodal, gshare; ENTRIES=64, CTR_W=2,
// GHR_W=8) share one directed stimulus stream. Expected values are worked out
// by hand in the comments next to each step.
// -----------------------------------------------------------------------------
module tb_branch_predictor_param;

   localparam logic [6:0] OP_BR   = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;
   localparam logic [6:0] OP_JALR = 7'b1100111;
   localparam logic [6:0] OP_ALU  = 7'b0110011;

   logic        CLK = 1'b0;
   logic        RST;
   logic        lookup_valid;
   logic [31:0] lookup_pc;
   logic        update_valid;
   logic [31:0] update_pc;
   logic [6:0]  update_opcode;
   logic [5:0]  update_idx;
   logic        update_taken;
   logic        update_pred_taken;
   logic [31:0] update_target;

   logic        s_valid, b_valid, g_valid;
   logic        s_taken, b_taken, g_taken;
   logic [31:0] s_target, b_target, g_target;
   logic [5:0]  s_idx, b_idx, g_idx;
   logic [31:0] s_bcnt, b_bcnt, g_bcnt;
   logic [31:0] s_mcnt, b_mcnt, g_mcnt;

   int checks = 0;
   int errors = 0;

   always #5 CLK = ~CLK;

   branch_predictor_param #(.ENTRIES(64), .CTR_W(2), .GHR_W(8), .MODE(0)) u_static (
      .CLK(CLK), .RST(RST), .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
      .pred_valid(s_valid), .pred_taken(s_taken), .pred_target(s_target), .pred_idx(s_idx),
      .update_valid(update_valid), .update_pc(update_pc), .update_opcode(update_opcode),
      .update_idx(update_idx), .update_taken(update_taken),
      .update_pred_taken(update_pred_taken), .update_target(update_target),
      .branch_count(s_bcnt), .mispredict_count(s_mcnt));

   branch_predictor_param #(.ENTRIES(64), .CTR_W(2), .GHR_W(8), .MODE(1)) u_bimodal (
      .CLK(CLK), .RST(RST), .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
      .pred_valid(b_valid), .pred_taken(b_taken), .pred_target(b_target), .pred_idx(b_idx),
      .update_valid(update_valid), .update_pc(update_pc), .update_opcode(update_opcode),
      .update_idx(update_idx), .update_taken(update_taken),
      .update_pred_taken(update_pred_taken), .update_target(update_target),
      .branch_count(b_bcnt), .mispredict_count(b_mcnt));

   branch_predictor_param #(.ENTRIES(64), .CTR_W(2), .GHR_W(8), .MODE(2)) u_gshare (
      .CLK(CLK), .RST(RST), .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
      .pred_valid(g_valid), .pred_taken(g_taken), .pred_target(g_target), .pred_idx(g_idx),
      .update_valid(update_valid), .update_pc(update_pc), .update_opcode(update_opcode),
      .update_idx(update_idx), .update_taken(update_taken),
      .update_pred_taken(update_pred_taken), .update_target(update_target),
      .branch_count(g_bcnt), .mispredict_count(g_mcnt));

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic set_update(input logic [31:0] pc, input logic [6:0] op, input logic [5:0] idx,
                             input logic tk, input logic ptk, input logic [31:0] tgt);
      update_valid      = 1'b1;
      update_pc         = pc;
      update_opcode     = op;
      update_idx        = idx;
      update_taken      = tk;
      update_pred_taken = ptk;
      update_target     = tgt;
   endtask

   task automatic upd(input logic [31:0] pc, input logic [6:0] op, input logic [5:0] idx,
                      input logic tk, input logic ptk, input logic [31:0] tgt);
      set_update(pc, op, idx, tk, ptk, tgt);
      tick();
      update_valid = 1'b0;
      $display("update pc=0x%08h op=%b idx=%0d taken=%0b pred=%0b target=0x%08h",
               pc, op, idx, tk, ptk, tgt);
   endtask

   task automatic look(input logic [31:0] pc);
      lookup_valid = 1'b1;
      lookup_pc    = pc;
      tick();
      lookup_valid = 1'b0;
      $display("lookup pc=0x%08h -> bimodal taken=%0b target=0x%08h idx=%0d",
               pc, b_taken, b_target, b_idx);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      RST = 1'b1;
      lookup_valid = 1'b0;
      lookup_pc = '0;
      update_valid = 1'b0;
      update_pc = '0;
      update_opcode = '0;
      update_idx = '0;
      update_taken = 1'b0;
      update_pred_taken = 1'b0;
      update_target = '0;

      // ---- reset state
      repeat (3) tick();
      chk("rst_pred_valid", 32'(b_valid), 32'd0);
      chk("rst_pred_target", b_target, 32'd0);
      chk("rst_branch_count", b_bcnt, 32'd0);
      chk("rst_mispredict", b_mcnt, 32'd0);
      RST = 1'b0;

      // ---- cold lookup: miss, not taken
      look(32'h100);
      chk("cold_valid", 32'(b_valid), 32'd1);
      chk("cold_taken", 32'(b_taken), 32'd0);
      chk("cold_target", b_target, 32'd0);
      chk("cold_idx", 32'(b_idx), 32'd0);
      chk("cold_static_valid", 32'(s_valid), 32'd1);
      tick();
      chk("valid_drops", 32'(b_valid), 32'd0);

      // ---- two taken branches: counter 1->2->3, GHR=0b11, counts 2/1
      upd(32'h100, OP_BR, 6'd0, 1'b1, 1'b0, 32'h80);
      upd(32'h100, OP_BR, 6'd0, 1'b1, 1'b1, 32'h80);
      chk("two_taken_bcnt", b_bcnt, 32'd2);
      chk("two_taken_mcnt", b_mcnt, 32'd1);
      look(32'h100);
      chk("bim_taken_after2", 32'(b_taken), 32'd1);
      chk("bim_target_after2", b_target, 32'h80);
      chk("static_cond_taken", 32'(s_taken), 32'd0);
      chk("static_cond_target", s_target, 32'h80);
      chk("gsh_idx_ghr3", 32'(g_idx), 32'd3);
      chk("gsh_taken_ghr3", 32'(g_taken), 32'd0);

      // ---- saturation: T (stays 3), NT (2, still taken), NT (1, not taken)
      upd(32'h100, OP_BR, 6'd0, 1'b1, 1'b1, 32'h80);
      upd(32'h100, OP_BR, 6'd0, 1'b0, 1'b1, 32'h80);
      look(32'h100);
      chk("sat_one_nt_taken", 32'(b_taken), 32'd1);
      chk("gsh_idx_ghr14", 32'(g_idx), 32'd14);
      upd(32'h100, OP_BR, 6'd0, 1'b0, 1'b1, 32'h80);
      look(32'h100);
      chk("sat_two_nt_taken", 32'(b_taken), 32'd0);
      chk("sat_target_kept", b_target, 32'h80);
      chk("gsh_idx_ghr28", 32'(g_idx), 32'd28);
      chk("sat_bcnt", b_bcnt, 32'd5);
      chk("sat_mcnt", b_mcnt, 32'd3);

      // ---- same index, different tag: miss
      look(32'h200);
      chk("alias_taken", 32'(b_taken), 32'd0);
      chk("alias_target", b_target, 32'd0);

      // ---- reset mid-stream with a lookup in flight
      lookup_valid = 1'b1;
      lookup_pc = 32'h100;
      tick();
      #2 RST = 1'b1;
      #1;
      chk("midrst_pred_valid", 32'(b_valid), 32'd0);
      chk("midrst_bcnt", b_bcnt, 32'd0);
      chk("midrst_mcnt", b_mcnt, 32'd0);
      chk("midrst_gsh_idx", 32'(g_idx), 32'd0);
      lookup_valid = 1'b0;
      tick();
      RST = 1'b0;
      tick();
      chk("post_rst_valid", 32'(b_valid), 32'd0);
      look(32'h100);
      chk("post_rst_taken", 32'(b_taken), 32'd0);
      chk("post_rst_target", b_target, 32'd0);

      // ---- JAL 0x200 -> 0x400: jump hit is taken in every mode
      upd(32'h200, OP_JAL, 6'd0, 1'b1, 1'b1, 32'h400);
      chk("jal_static_bcnt", s_bcnt, 32'd1);
      look(32'h200);
      chk("jal_static_taken", 32'(s_taken), 32'd1);
      chk("jal_static_target", s_target, 32'h400);
      chk("jal_bim_taken", 32'(b_taken), 32'd1);
      chk("jal_gsh_taken", 32'(g_taken), 32'd1);
      chk("jal_gsh_idx", 32'(g_idx), 32'd0);

      // ---- JALR 0x304 -> 0x500 (index 1)
      upd(32'h304, OP_JALR, 6'd1, 1'b1, 1'b1, 32'h500);
      look(32'h304);
      chk("jalr_taken", 32'(b_taken), 32'd1);
      chk("jalr_target", b_target, 32'h500);
      chk("jalr_gsh_idx", 32'(g_idx), 32'd1);

      // ---- counter back to 1 with a valid BTB entry: T (2), NT (1); GHR=0b10
      upd(32'h100, OP_BR, 6'd0, 1'b1, 1'b0, 32'h88);
      upd(32'h100, OP_BR, 6'd0, 1'b0, 1'b1, 32'h88);

      // ---- simultaneous lookup + taken update at index 0
      lookup_valid = 1'b1;
      lookup_pc = 32'h100;
      set_update(32'h100, OP_BR, 6'd0, 1'b1, 1'b1, 32'h88);
      tick();
      lookup_valid = 1'b0;
      update_valid = 1'b0;
      $display("lookup+update pc=0x00000100 -> bimodal taken=%0b", b_taken);
      chk("rbw_old_taken", 32'(b_taken), 32'd0);
      chk("rbw_target", b_target, 32'h88);
      chk("rbw_gsh_idx", 32'(g_idx), 32'd2);
      look(32'h100);
      chk("rbw_new_taken", 32'(b_taken), 32'd1);
      chk("rbw_gsh_idx_after", 32'(g_idx), 32'd5);
      chk("rbw_bcnt", b_bcnt, 32'd5);
      chk("rbw_mcnt", b_mcnt, 32'd2);

      // ---- non-control opcode is ignored entirely
      upd(32'h400, OP_ALU, 6'd0, 1'b1, 1'b0, 32'h999);
      chk("alu_bcnt", b_bcnt, 32'd5);
      chk("alu_mcnt", b_mcnt, 32'd2);
      look(32'h400);
      chk("alu_no_btb", b_target, 32'd0);
      chk("alu_no_ghr", 32'(g_idx), 32'd5);

      // ---- real mispredicted branch counts
      upd(32'h100, OP_BR, 6'd0, 1'b1, 1'b0, 32'h88);
      chk("br_bcnt", b_bcnt, 32'd6);
      chk("br_mcnt", b_mcnt, 32'd3);

      // ---- final asynchronous reset clears the counters in all modes
      #2 RST = 1'b1;
      #1;
      chk("final_rst_bcnt", b_bcnt, 32'd0);
      chk("final_rst_mcnt", b_mcnt, 32'd0);
      chk("final_rst_static_bcnt", s_bcnt, 32'd0);
      chk("final_rst_gsh_mcnt", g_mcnt, 32'd0);
      tick();
      RST = 1'b0;
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
